// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the accumulator CPU sequencer:
// opcodes, FSM state encodings and field widths.
package cpu_ctrl_pkg;

  localparam int OPCODE_LEN = 3;

  typedef logic [OPCODE_LEN-1:0] opcode_t;

  localparam opcode_t OP_IN   = 3'b000;
  localparam opcode_t OP_OUT  = 3'b001;
  localparam opcode_t OP_INC  = 3'b010;
  localparam opcode_t OP_DEC  = 3'b011;
  localparam opcode_t OP_JMP  = 3'b100;
  localparam opcode_t OP_JZ   = 3'b101;
  localparam opcode_t OP_JPOS = 3'b110;
  localparam opcode_t OP_HALT = 3'b111;

  typedef enum logic [2:0] {
    S_INIT    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXEC    = 3'd3,
    S_IN_WAIT = 3'd4,
    S_IN_REL  = 3'd5,
    S_SETTLE  = 3'd6,
    S_HALT    = 3'd7
  } state_t;

endpackage

// File: rtl/control_unit.sv
// Multi-cycle sequencer: fetch/decode/execute phases,
// IN handshake on Enter, sticky HALT.
module control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int INIT_CYCLES = 2
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [OPCODE_LEN-1:0] Opcode,
  input  logic                  Azero,
  input  logic                  Apos,
  input  logic                  Enter,
  output logic                  IRload,
  output logic                  PCload,
  output logic                  Jmux,
  output logic                  Aload,
  output logic                  Asel,
  output logic                  Sub,
  output logic                  Outen,
  output logic                  Halt,
  output logic [2:0]            State
);

  localparam int CW = $clog2(INIT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(INIT_CYCLES - 1);

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] cnt_q;
  logic          init_done;

  assign init_done = (cnt_q == CNT_LAST);
  assign State     = state_q;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Counter only runs while in INIT; it is idle at zero otherwise.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      cnt_q <= '0;
    end else if (state_q == S_INIT && !init_done) begin
      cnt_q <= cnt_q + 1'b1;
    end else begin
      cnt_q <= '0;
    end
  end

  always_comb begin
    state_d = S_INIT;
    case (state_q)
      S_INIT:    state_d = init_done ? S_FETCH : S_INIT;
      S_FETCH:   state_d = S_DECODE;
      S_DECODE: begin
        if (Opcode == OP_IN) begin
          state_d = S_IN_WAIT;
        end else if (Opcode == OP_HALT) begin
          state_d = S_HALT;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC:    state_d = S_SETTLE;
      S_IN_WAIT: state_d = Enter ? S_IN_REL : S_IN_WAIT;
      S_IN_REL:  state_d = Enter ? S_IN_REL : S_SETTLE;
      S_SETTLE:  state_d = S_FETCH;
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_INIT;
    endcase
  end

  always_comb begin
    IRload = 1'b0;
    PCload = 1'b0;
    Jmux   = 1'b1;
    Aload  = 1'b0;
    Asel   = 1'b0;
    Sub    = 1'b0;
    Outen  = 1'b0;
    Halt   = 1'b0;
    case (state_q)
      S_FETCH: begin
        IRload = 1'b1;
        PCload = 1'b1;
      end
      S_EXEC: begin
        unique case (1'b1)
          (Opcode == OP_OUT):  Outen = 1'b1;
          (Opcode == OP_INC):  Aload = 1'b1;
          (Opcode == OP_DEC): begin
            Aload = 1'b1;
            Sub   = 1'b1;
          end
          (Opcode == OP_JMP): begin
            PCload = 1'b1;
            Jmux   = 1'b0;
          end
          (Opcode == OP_JZ): begin
            PCload = Azero;
            Jmux   = 1'b0;
          end
          (Opcode == OP_JPOS): begin
            PCload = Apos;
            Jmux   = 1'b0;
          end
          default: ;
        endcase
      end
      S_IN_WAIT: begin
        Aload = Enter;
        Asel  = Enter;
      end
      S_HALT:  Halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: directed cycles push
// expected state/outputs, a negedge monitor pops and compares.
module tb_control_unit;
  import cpu_ctrl_pkg::*;

  logic       Clock;
  logic       Reset;
  logic [2:0] Opcode;
  logic       Azero;
  logic       Apos;
  logic       Enter;
  logic       IRload;
  logic       PCload;
  logic       Jmux;
  logic       Aload;
  logic       Asel;
  logic       Sub;
  logic       Outen;
  logic       Halt;
  logic [2:0] State;

  control_unit #(.INIT_CYCLES(2)) dut (
    .Clock  (Clock),
    .Reset  (Reset),
    .Opcode (Opcode),
    .Azero  (Azero),
    .Apos   (Apos),
    .Enter  (Enter),
    .IRload (IRload),
    .PCload (PCload),
    .Jmux   (Jmux),
    .Aload  (Aload),
    .Asel   (Asel),
    .Sub    (Sub),
    .Outen  (Outen),
    .Halt   (Halt),
    .State  (State)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // {IRload,PCload,Jmux,Aload,Asel,Sub,Outen,Halt}
  localparam logic [7:0] O_IDLE  = 8'b0010_0000;
  localparam logic [7:0] O_FETCH = 8'b1110_0000;
  localparam logic [7:0] O_INC   = 8'b0011_0000;
  localparam logic [7:0] O_DEC   = 8'b0011_0100;
  localparam logic [7:0] O_JTAK  = 8'b0100_0000;
  localparam logic [7:0] O_JNOT  = 8'b0000_0000;
  localparam logic [7:0] O_OUT   = 8'b0010_0010;
  localparam logic [7:0] O_INLD  = 8'b0011_1000;
  localparam logic [7:0] O_HALT  = 8'b0010_0001;

  localparam logic [2:0] T_INIT = 3'd0;
  localparam logic [2:0] T_FET  = 3'd1;
  localparam logic [2:0] T_DEC  = 3'd2;
  localparam logic [2:0] T_EXE  = 3'd3;
  localparam logic [2:0] T_INW  = 3'd4;
  localparam logic [2:0] T_INR  = 3'd5;
  localparam logic [2:0] T_SET  = 3'd6;
  localparam logic [2:0] T_HLT  = 3'd7;

  typedef struct packed {
    logic [2:0] st;
    logic [7:0] o;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc_no = 0;

  always @(negedge Clock) begin
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_chk++;
      if (State !== e.st) begin
        n_fail++;
        $display("FAIL state cyc=%0d: got %0d want %0d",
                 cyc_no, State, e.st);
      end
      n_chk++;
      if ({IRload, PCload, Jmux, Aload, Asel, Sub, Outen, Halt}
          !== e.o) begin
        n_fail++;
        $display("FAIL outputs cyc=%0d: got %b want %b", cyc_no,
                 {IRload, PCload, Jmux, Aload, Asel, Sub, Outen,
                  Halt}, e.o);
      end
    end
  end

  task automatic cyc(input logic rst, input logic [2:0] op,
                     input logic az, input logic ap,
                     input logic en, input logic [2:0] st,
                     input logic [7:0] o);
    exp_t x;
    @(posedge Clock);
    #1;
    Reset  = rst;
    Opcode = op;
    Azero  = az;
    Apos   = ap;
    Enter  = en;
    cyc_no++;
    x.st = st;
    x.o  = o;
    sb.push_back(x);
  endtask

  task automatic instr(input logic [2:0] op, input logic az,
                       input logic ap, input logic [7:0] eo);
    cyc(1'b1, op, az, ap, 1'b0, T_FET, O_FETCH);
    cyc(1'b1, op, az, ap, 1'b0, T_DEC, O_IDLE);
    cyc(1'b1, op, az, ap, 1'b0, T_EXE, eo);
    cyc(1'b1, op, az, ap, 1'b0, T_SET, O_IDLE);
  endtask

  initial begin
    Reset  = 1'b0;
    Opcode = 3'b000;
    Azero  = 1'b0;
    Apos   = 1'b0;
    Enter  = 1'b0;

    cyc(1'b0, OP_INC, 0, 0, 0, T_INIT, O_IDLE);
    cyc(1'b1, OP_INC, 0, 0, 0, T_INIT, O_IDLE);
    cyc(1'b1, OP_INC, 0, 0, 0, T_INIT, O_IDLE);

    instr(OP_INC,  1'b0, 1'b0, O_INC);
    instr(OP_DEC,  1'b0, 1'b1, O_DEC);
    instr(OP_JZ,   1'b0, 1'b1, O_JNOT);
    instr(OP_JZ,   1'b1, 1'b0, O_JTAK);
    instr(OP_JPOS, 1'b0, 1'b1, O_JTAK);
    instr(OP_JPOS, 1'b1, 1'b0, O_JNOT);
    instr(OP_JMP,  1'b0, 1'b0, O_JTAK);
    instr(OP_OUT,  1'b1, 1'b1, O_OUT);

    // IN: Enter low 5 cycles, high 3, then released
    cyc(1'b1, OP_IN, 0, 0, 0, T_FET, O_FETCH);
    cyc(1'b1, OP_IN, 0, 0, 0, T_DEC, O_IDLE);
    for (int i = 0; i < 5; i++)
      cyc(1'b1, OP_IN, 0, 0, 0, T_INW, O_IDLE);
    cyc(1'b1, OP_IN, 0, 0, 1, T_INW, O_INLD);
    cyc(1'b1, OP_IN, 0, 0, 1, T_INR, O_IDLE);
    cyc(1'b1, OP_IN, 0, 0, 1, T_INR, O_IDLE);
    cyc(1'b1, OP_IN, 0, 0, 0, T_INR, O_IDLE);
    cyc(1'b1, OP_IN, 0, 0, 0, T_SET, O_IDLE);

    // IN with Enter already high: minimum 5-cycle form
    cyc(1'b1, OP_IN, 0, 0, 1, T_FET, O_FETCH);
    cyc(1'b1, OP_IN, 0, 0, 1, T_DEC, O_IDLE);
    cyc(1'b1, OP_IN, 0, 0, 1, T_INW, O_INLD);
    cyc(1'b1, OP_IN, 0, 0, 0, T_INR, O_IDLE);
    cyc(1'b1, OP_IN, 0, 0, 0, T_SET, O_IDLE);

    // Reset drops right as INC enters EXEC
    cyc(1'b1, OP_INC, 0, 0, 0, T_FET, O_FETCH);
    cyc(1'b1, OP_INC, 0, 0, 0, T_DEC, O_IDLE);
    cyc(1'b0, OP_INC, 0, 0, 0, T_INIT, O_IDLE);
    cyc(1'b0, OP_INC, 0, 0, 0, T_INIT, O_IDLE);
    cyc(1'b0, OP_INC, 0, 0, 0, T_INIT, O_IDLE);
    cyc(1'b1, OP_HALT, 0, 0, 0, T_INIT, O_IDLE);
    cyc(1'b1, OP_HALT, 0, 0, 0, T_INIT, O_IDLE);
    cyc(1'b1, OP_HALT, 0, 0, 0, T_FET, O_FETCH);

    // HALT is sticky regardless of inputs
    cyc(1'b1, OP_HALT, 0, 0, 0, T_DEC, O_IDLE);
    for (int i = 0; i < 20; i++)
      cyc(1'b1, OP_HALT, i[0], i[1], i[2], T_HLT, O_HALT);
    cyc(1'b0, OP_HALT, 0, 0, 0, T_INIT, O_IDLE);
    cyc(1'b0, OP_HALT, 0, 0, 0, T_INIT, O_IDLE);

    @(posedge Clock);
    @(negedge Clock);
    #1;
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Multi-cycle sequencer for the accumulator CPU. It drives the fetch datapath (PC, IR and the synchronous-read program memory) and the accumulator datapath through fixed instruction phases. It decodes the 3-bit opcode held in IR, evaluates branch flags, and runs an Enter/Input handshake for IN. It also stops the machine on HALT.

## Interface
- OPCODE_LEN, 3, opcode width; top OPCODE_LEN bits of IR, supplied by the datapath.
- INIT_CYCLES, 2, cycles held in INIT after reset so program memory can present address 0; legal values are ≥2.
- Clock  in  1  single rising-edge clock.
- Reset  in  1  asynchronous, active-low reset.
- Opcode  in  OPCODE_LEN  opcode field of the current IR.
- Azero  in  1  accumulator == 0.
- Apos  in  1  accumulator > 0 (signed, nonzero).
- Enter  in  1  operator strobe for IN; level input, already synchronised.
- IRload  out  1  IR <= program memory output at the next edge.
- PCload  out  1  PC <= PC_NXT at the next edge.
- Jmux  out  1  PC_NXT select: 1 = PC+1, 0 = IR address field.
- Aload  out  1  accumulator load enable.
- Asel  out  1  accumulator source: 0 = ALU, 1 = external Input.
- Sub  out  1  ALU op: 0 = A+1, 1 = A−1.
- Outen  out  1  one-cycle pulse; output register <= A.
- Halt  out  1  machine stopped.
- State  out  3  current state encoding, for debug.

## Operation
- States: INIT, FETCH, DECODE, EXEC, IN_WAIT, IN_REL, SETTLE, HALT.
- INIT: an internal counter runs INIT_CYCLES cycles, then the FSM goes to FETCH.
- FETCH asserts IRload=1, PCload=1 and Jmux=1, so IR <= mem[PC] and PC <= PC+1. Next state is DECODE.
- DECODE has no outputs. Next state is IN_WAIT if Opcode=000, HALT if Opcode=111, otherwise EXEC.
- EXEC actions by opcode:
  - 001 OUT: Outen=1.
  - 010 INC: Aload=1, Asel=0, Sub=0.
  - 011 DEC: Aload=1, Asel=0, Sub=1.
  - 100 JMP: PCload=1, Jmux=0.
  - 101 JZ: PCload=Azero, Jmux=0.
  - 110 JPOS: PCload=Apos, Jmux=0.
  - After any EXEC, next state is SETTLE.
- IN (000):
  - IN_WAIT holds until Enter=1. In that cycle it asserts Aload=1 and Asel=1, then moves to IN_REL.
  - IN_REL holds until Enter=0, then moves to SETTLE.
  - One held Enter loads exactly once.
- SETTLE has no outputs; it always moves to FETCH. It guarantees the memory output for the new PC is valid before IRload.
- HALT asserts Halt=1. No other outputs are active. It is sticky until Reset.
- Undriven outputs default to 0, except Jmux, which defaults to 1.
- Opcode is sampled combinationally in DECODE and EXEC. IR is stable across both because IRload=1 only in FETCH.

## Timing
- Reset low asynchronously forces State=INIT and clears the INIT counter. Outputs go to IRload=PCload=Aload=Asel=Sub=Outen=Halt=0 and Jmux=1.
- This holds even mid-instruction or mid-handshake. No partial load is issued after Reset asserts.
- Reset release is synchronous to Clock. The first FETCH is INIT_CYCLES cycles after the first rising edge with Reset high.
- All outputs are combinational decodes of the state register and inputs. The datapath consumes them at the next rising edge.
- Non-IN instructions take 4 cycles (FETCH, DECODE, EXEC, SETTLE). HALT stops at DECODE+1.
- IN takes 4 + (cycles waiting for Enter) + (cycles waiting for Enter release) cycles, minimum 5.
- Branch flags are evaluated only in the EXEC cycle.
- If Enter is already high on entering IN_WAIT, the load happens in that first cycle.
- PC wrap-around (max→0) is a datapath property. The controller is agnostic to it.
- State encoding uses 3 bits. Unreachable encodings go to INIT at the next edge.

## Structure
- Shared package cpu_ctrl_pkg holds:
  - opcode constants OP_IN, OP_OUT, OP_INC, OP_DEC, OP_JMP, OP_JZ, OP_JPOS, OP_HALT;
  - the state enum and its 3-bit encodings;
  - OPCODE_LEN.
- A single module with no sub-modules. The FSM, INIT counter and output decode all live in control_unit.

## Test plan
- Reset low for 3 cycles mid-EXEC of INC → Aload=0 immediately, State=INIT, Jmux=1. After release, IRload=1 exactly 2 cycles later.
- Opcode=010 after FETCH → Aload=1, Asel=0, Sub=0 in the third cycle only. The next IRload is 4 cycles after the previous one.
- Opcode=101 with Azero=0, then again with Azero=1 → PCload=0 in the first EXEC. In the second, PCload=1 and Jmux=0. SETTLE follows in both cases.
- Opcode=000 with Enter low for 5 cycles, high for 3, then low → exactly one Aload=1 with Asel=1, in the first Enter-high cycle. FETCH follows 2 cycles after Enter falls (IN_REL exit, then SETTLE).
- Opcode=111 → Halt=1 from the cycle after DECODE. No IRload/PCload for 20 cycles. Reset clears Halt asynchronously.
- Opcode=001 → a single Outen pulse lasting 1 cycle, with Aload=0 and PCload=0 in that cycle.
